alu: RTL and testbench

8-bit 8085-style arithmetic/logic unit for the core datapath. It computes one of eight operations on two bytes with full PSW flag generation. The result and flags are combinational. An optional flag register captures the flags on a clock edge for the control unit.

---
 rtl/alu.sv | 106 ++++++++++
 tb/tb_alu.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 8085-style ALU: eight operations with PSW flags, all combinational.
// Define ALU_FLAGREG_EN to add the clocked flag register behind oR.
module alu #(
  parameter int DATASIZE = 8,
  parameter int FLAG_S   = 7,
  parameter int FLAG_Z   = 6,
  parameter int FLAG_A   = 4,
  parameter int FLAG_P   = 2,
  parameter int FLAG_C   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          iS,
  input  logic [DATASIZE-1:0] iA,
  input  logic [DATASIZE-1:0] iB,
  input  logic [DATASIZE-1:0] iF,
  input  logic                iE,
  output logic [DATASIZE-1:0] oY,
  output logic [DATASIZE-1:0] oF,
  output logic [DATASIZE-1:0] oR
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SBB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  logic                is_sub;
  logic                cin_raw;
  logic                cin;
  logic [DATASIZE-1:0] op_b;
  logic [DATASIZE:0]   sum;
  logic [4:0]          nib;
  logic                arith_c;
  logic                arith_a;
  logic [DATASIZE-1:0] flag_src;
  logic                aux;

  // One adder serves all arithmetic: subtraction is A + ~B + ~borrow, carries inverted.
  assign is_sub  = (iS == OP_SUB) || (iS == OP_SBB) || (iS == OP_CMP);
  assign cin_raw = ((iS == OP_ADC) || (iS == OP_SBB)) ? iF[FLAG_C] : 1'b0;
  assign cin     = is_sub ? ~cin_raw : cin_raw;
  assign op_b    = is_sub ? ~iB : iB;
  assign sum     = {1'b0, iA} + {1'b0, op_b} + {{DATASIZE{1'b0}}, cin};
  assign nib     = {1'b0, iA[3:0]} + {1'b0, op_b[3:0]} + {4'b0000, cin};
  assign arith_c = is_sub ? ~sum[DATASIZE] : sum[DATASIZE];
  assign arith_a = is_sub ? ~nib[4] : nib[4];

  always_comb begin
    oY       = sum[DATASIZE-1:0];
    flag_src = sum[DATASIZE-1:0];
    aux      = arith_a;
    unique case (iS)
      OP_AND: begin
        oY  = iA & iB;
        aux = iA[3] | iB[3];
      end
      OP_XOR: begin
        oY  = iA ^ iB;
        aux = 1'b0;
      end
      OP_OR: begin
        oY  = iA | iB;
        aux = 1'b0;
      end
      OP_CMP: oY = iA;
      default: ;
    endcase
    if (iS != OP_CMP) flag_src = oY;
  end

  always_comb begin
    oF         = '0;
    oF[1]      = 1'b1;
    oF[FLAG_S] = flag_src[DATASIZE-1];
    oF[FLAG_Z] = (flag_src == '0);
    oF[FLAG_A] = aux;
    oF[FLAG_P] = ~^flag_src;
    oF[FLAG_C] = iS[2] ? (iS == OP_CMP) & arith_c : arith_c;
  end

`ifdef ALU_FLAGREG_EN
  logic [DATASIZE-1:0] flags_q;
  logic [DATASIZE-1:0] flags_d;
  logic                unused_inputs;

  assign flags_d       = iE ? oF : flags_q;
  assign unused_inputs = &{1'b0, iF};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign oR = flags_q;
`else
  logic unused_inputs;
  assign unused_inputs = &{1'b0, clk, rst, iE, iF};
  assign oR = oF;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed vector table, flag-register sequence and exhaustive sweep for alu.
// Flag-register checks follow ALU_FLAGREG_EN as the DUT does.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] iS;
  logic [7:0] iA, iB, iF;
  logic       iE;
  logic [7:0] oY, oF, oR;

  int n_vec = 0;
  int n_bad = 0;

  alu dut (
    .clk(clk), .rst(rst), .iS(iS), .iA(iA), .iB(iB), .iF(iF),
    .iE(iE), .oY(oY), .oF(oF), .oR(oR)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] s;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] y;
    logic [7:0] f;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // Reference written from the operation definitions with plain integer arithmetic.
  function automatic logic [15:0] model(input int s, input int a, input int b, input int c);
    int r;
    int cin;
    logic [7:0] y, src, f;
    logic cy, ax;
    cy = 1'b0;
    ax = 1'b0;
    case (s)
      0, 1: begin
        cin = (s == 1) ? c : 0;
        r   = a + b + cin;
        y   = r[7:0];
        src = y;
        cy  = (r > 255);
        ax  = ((a % 16) + (b % 16) + cin) > 15;
      end
      2, 3, 7: begin
        cin = (s == 3) ? c : 0;
        r   = (a - b - cin + 512) % 256;
        src = r[7:0];
        y   = (s == 7) ? a[7:0] : src;
        cy  = (a < b + cin);
        ax  = ((a % 16) < (b % 16) + cin);
      end
      4: begin
        y   = a[7:0] & b[7:0];
        src = y;
        ax  = (((a >> 3) & 1) | ((b >> 3) & 1)) != 0;
      end
      5: begin y = a[7:0] ^ b[7:0]; src = y; end
      default: begin y = a[7:0] | b[7:0]; src = y; end
    endcase
    f = {src[7], (src == 8'h00), 1'b0, ax, 1'b0, ~^src, 1'b1, cy};
    return {y, f};
  endfunction

  initial begin
    logic [7:0] exp_r;
    logic [15:0] m;
    int errs;
    string first;

    tbl[0]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h57};
    tbl[1]  = '{3'd2, 8'h00, 8'h01, 1'b0, 8'hFF, 8'h97};
    tbl[2]  = '{3'd1, 8'h7F, 8'h00, 1'b1, 8'h80, 8'h92};
    tbl[3]  = '{3'd3, 8'h10, 8'h0F, 1'b1, 8'h00, 8'h56};
    tbl[4]  = '{3'd4, 8'hF0, 8'h0F, 1'b0, 8'h00, 8'h56};
    tbl[5]  = '{3'd5, 8'hAA, 8'h55, 1'b0, 8'hFF, 8'h86};
    tbl[6]  = '{3'd6, 8'h00, 8'h00, 1'b0, 8'h00, 8'h46};
    tbl[7]  = '{3'd7, 8'h05, 8'h05, 1'b0, 8'h05, 8'h46};
    tbl[8]  = '{3'd7, 8'h05, 8'h06, 1'b0, 8'h05, 8'h97};
    tbl[9]  = '{3'd0, 8'h3A, 8'h28, 1'b1, 8'h62, 8'h12};
    tbl[10] = '{3'd2, 8'h80, 8'h01, 1'b1, 8'h7F, 8'h12};
    tbl[11] = '{3'd4, 8'h0C, 8'h0A, 1'b1, 8'h08, 8'h12};
    tbl[12] = '{3'd6, 8'h01, 8'h02, 1'b1, 8'h03, 8'h06};
    tbl[13] = '{3'd1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 8'h97};
    tbl[14] = '{3'd3, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h57};
    tbl[15] = '{3'd7, 8'h06, 8'h05, 1'b1, 8'h06, 8'h02};

    rst = 1'b1;
    iE  = 1'b0;
    iS  = 3'd0;
    iA  = 8'h00;
    iB  = 8'h00;
    iF  = 8'h00;
    #1;
`ifdef ALU_FLAGREG_EN
    chk("reset_oR", oR, 8'h00);
`endif

    // Reset stays asserted here, so a registered oR must read zero throughout.
    for (int i = 0; i < 16; i++) begin
      iS = tbl[i].s;
      iA = tbl[i].a;
      iB = tbl[i].b;
      iF = {7'h7A, tbl[i].c};
      #1;
`ifdef ALU_FLAGREG_EN
      exp_r = 8'h00;
`else
      exp_r = tbl[i].f;
`endif
      $display("vec %0d: op=%0d a=%02h b=%02h c=%0b -> y=%02h f=%02h r=%02h",
               i, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].c, oY, oF, oR);
      chk($sformatf("vec%0d_oY", i), oY, tbl[i].y);
      chk($sformatf("vec%0d_oF", i), oF, tbl[i].f);
      chk($sformatf("vec%0d_oR", i), oR, exp_r);
    end

`ifdef ALU_FLAGREG_EN
    @(negedge clk);
    rst = 1'b0;
    iS = 3'd0; iA = 8'hFF; iB = 8'h01; iF = 8'h00; iE = 1'b1;
    @(posedge clk); #1;
    chk("reg_load_add", oR, 8'h57);

    @(negedge clk);
    iE = 1'b0; iS = 3'd2; iA = 8'h00; iB = 8'h01;
    @(posedge clk); #1;
    chk("reg_hold", oR, 8'h57);
    chk("reg_hold_oF", oF, 8'h97);

    @(negedge clk);
    iE = 1'b1;
    @(posedge clk); #1;
    chk("reg_load_sub", oR, 8'h97);

    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("reg_async_rst", oR, 8'h00);
    @(posedge clk); #1;
    chk("reg_rst_over_iE", oR, 8'h00);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reg_after_rst", oR, 8'h97);
`endif

    for (int s = 0; s < 8; s++) begin
      errs  = 0;
      first = "";
      for (int a = 0; a < 256; a++) begin
        for (int b = 0; b < 256; b++) begin
          int c;
          c  = (a ^ (b >> 1)) & 1;
          iS = s[2:0];
          iA = a[7:0];
          iB = b[7:0];
          iF = {7'h00, c[0]};
          #1;
          m = model(s, a, b, c);
          if (oY !== m[15:8] || oF !== m[7:0]
`ifndef ALU_FLAGREG_EN
              || oR !== m[7:0]
`endif
             ) begin
            if (errs == 0)
              first = $sformatf("a=%02h b=%02h c=%0d got y=%02h f=%02h r=%02h expected y=%02h f=%02h",
                                a, b, c, oY, oF, oR, m[15:8], m[7:0]);
            errs++;
          end
        end
      end
      n_vec++;
      if (errs != 0) begin
        n_bad++;
        $display("FAIL sweep_op%0d: %0d bad of 65536, first %s", s, errs, first);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
